// File: rtl/mem_wb_stage_pkg.sv
// Shared MEM->WB pipeline definitions: default field widths, payload layout
// and the occupancy-coded FSM states.
package mem_wb_stage_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 4;
    localparam int DEF_PC_W       = 32;

    // State value doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic                      wb_en;
        logic                      mem_r_en;
        logic [DEF_DATA_W-1:0]     alu_res;
        logic [DEF_DATA_W-1:0]     mem_data;
        logic [DEF_REG_ADDR_W-1:0] dest;
        logic [DEF_PC_W-1:0]       pc;
    } wb_payload_t;

    function automatic int payload_w(input int data_w, input int reg_w, input int pc_w);
        return 2 + 2 * data_w + reg_w + pc_w;
    endfunction

endpackage

// File: rtl/wb_payload_reg.sv
// Enable-loaded payload register with synchronous active-low clear.
module wb_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_ld,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: valid/ready handshake, flush, optional 2-entry skid,
// write-back value select and forwarding strobe.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int PC_W       = DEF_PC_W,
    parameter bit SKID       = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wb_en,
    input  logic                  in_mem_r_en,
    input  logic [DATA_W-1:0]     in_alu_res,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [PC_W-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_wb_en,
    output logic                  out_mem_r_en,
    output logic [DATA_W-1:0]     out_alu_res,
    output logic [DATA_W-1:0]     out_mem_data,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [PC_W-1:0]       out_pc,
    output logic [DATA_W-1:0]     out_wb_value,
    output logic                  fwd_valid,
    output logic [1:0]            occupancy
);

    localparam int PL_W = payload_w(DATA_W, REG_ADDR_W, PC_W);

    state_e          r_state;
    state_e          w_state_next;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_out_valid;
    logic            w_main_ld;
    logic            w_skid_ld;
    logic            w_from_skid;
    logic            w_h_wb_en;
    logic            w_h_mem_r_en;
    logic [PL_W-1:0] w_in_pl;
    logic [PL_W-1:0] w_main_d;
    logic [PL_W-1:0] w_main_q;
    logic [PL_W-1:0] w_skid_q;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = w_out_valid & out_ready;
    assign w_in_pl     = {in_wb_en, in_mem_r_en, in_alu_res, in_mem_data, in_dest, in_pc};

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_main_ld    = 1'b0;
        w_skid_ld    = 1'b0;
        w_from_skid  = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_next = ST_BUSY;
                    w_main_ld    = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_in_fire && (w_out_fire || !SKID)) begin
                    w_main_ld = 1'b1;
                end else if (w_in_fire) begin
                    w_state_next = ST_FULL;
                    w_skid_ld    = 1'b1;
                end else if (w_out_fire) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_state_next = ST_BUSY;
                    w_main_ld    = 1'b1;
                    w_from_skid  = 1'b1;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
        // A flushed cycle leaves payload untouched; the accepted entry is simply dropped.
        if (flush) begin
            w_main_ld = 1'b0;
            w_skid_ld = 1'b0;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic r_in_ready;

            always_ff @(posedge clk) begin
                if (!rst || flush) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_next != ST_FULL);
                end
            end

            assign in_ready = r_in_ready;

            wb_payload_reg #(.W(PL_W)) u_skid (
                .clk  (clk),
                .rst  (rst),
                .i_ld (w_skid_ld),
                .i_d  (w_in_pl),
                .o_q  (w_skid_q)
            );
        end else begin : g_single
            assign in_ready = out_ready | ~w_out_valid;
            assign w_skid_q = '0;
        end
    endgenerate

    assign w_main_d = w_from_skid ? w_skid_q : w_in_pl;

    wb_payload_reg #(.W(PL_W)) u_main (
        .clk  (clk),
        .rst  (rst),
        .i_ld (w_main_ld),
        .i_d  (w_main_d),
        .o_q  (w_main_q)
    );

    assign {w_h_wb_en, w_h_mem_r_en, out_alu_res, out_mem_data, out_dest, out_pc} = w_main_q;

    assign out_valid    = w_out_valid;
    assign out_wb_en    = w_out_valid & w_h_wb_en;
    assign out_mem_r_en = w_out_valid & w_h_mem_r_en;
    assign out_wb_value = out_mem_r_en ? out_mem_data : out_alu_res;
    assign fwd_valid    = w_out_valid & out_wb_en;
    assign occupancy    = r_state;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: SKID=1 and SKID=0 instances share stimulus; directed
// table, hand sequences, then random traffic against a queue model.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic        in_wb_en, in_mem_r_en;
    logic [31:0] in_alu_res, in_mem_data, in_pc;
    logic [3:0]  in_dest;

    logic        s_in_ready, s_valid, s_wb_en, s_mr_en, s_fwd;
    logic [31:0] s_alu, s_mdata, s_pc, s_wbv;
    logic [3:0]  s_dest;
    logic [1:0]  s_occ;

    logic        z_in_ready, z_valid, z_wb_en, z_mr_en, z_fwd;
    logic [31:0] z_alu, z_mdata, z_pc, z_wbv;
    logic [3:0]  z_dest;
    logic [1:0]  z_occ;

    mem_wb_stage #(.SKID(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_alu_res(in_alu_res),
        .in_mem_data(in_mem_data), .in_dest(in_dest), .in_pc(in_pc),
        .out_valid(s_valid), .out_ready(out_ready), .out_wb_en(s_wb_en), .out_mem_r_en(s_mr_en),
        .out_alu_res(s_alu), .out_mem_data(s_mdata), .out_dest(s_dest), .out_pc(s_pc),
        .out_wb_value(s_wbv), .fwd_valid(s_fwd), .occupancy(s_occ)
    );

    mem_wb_stage #(.SKID(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_alu_res(in_alu_res),
        .in_mem_data(in_mem_data), .in_dest(in_dest), .in_pc(in_pc),
        .out_valid(z_valid), .out_ready(out_ready), .out_wb_en(z_wb_en), .out_mem_r_en(z_mr_en),
        .out_alu_res(z_alu), .out_mem_data(z_mdata), .out_dest(z_dest), .out_pc(z_pc),
        .out_wb_value(z_wbv), .fwd_valid(z_fwd), .occupancy(z_occ)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wb, input logic mr, input logic [31:0] alu,
                         input logic [31:0] md, input logic [3:0] dest, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        in_valid    = v;
        in_wb_en    = wb;
        in_mem_r_en = mr;
        in_alu_res  = alu;
        in_mem_data = md;
        in_dest     = dest;
        in_pc       = pc;
        out_ready   = rdy;
        flush       = fl;
    endtask

    // Compare one instance's outputs against the model's view of its queue.
    task automatic check_dut(input string tag, input int size, input wb_payload_t h,
                             input logic ov, input logic wb, input logic mr,
                             input logic [31:0] alu, input logic [31:0] md, input logic [3:0] dest,
                             input logic [31:0] pc, input logic [31:0] wbv, input logic fwd,
                             input logic [1:0] occ);
        check({tag, "_valid"}, 64'(ov), 64'(size > 0));
        check({tag, "_occ"}, 64'(occ), 64'(size));
        if (size > 0) begin
            check({tag, "_wb_en"}, 64'(wb), 64'(h.wb_en));
            check({tag, "_mem_r_en"}, 64'(mr), 64'(h.mem_r_en));
            check({tag, "_alu"}, 64'(alu), 64'(h.alu_res));
            check({tag, "_mdata"}, 64'(md), 64'(h.mem_data));
            check({tag, "_dest"}, 64'(dest), 64'(h.dest));
            check({tag, "_pc"}, 64'(pc), 64'(h.pc));
            check({tag, "_wbv"}, 64'(wbv), 64'(h.mem_r_en ? h.mem_data : h.alu_res));
            check({tag, "_fwd"}, 64'(fwd), 64'(h.wb_en));
        end else begin
            check({tag, "_wb_en_idle"}, 64'(wb), 64'd0);
            check({tag, "_mem_r_en_idle"}, 64'(mr), 64'd0);
            check({tag, "_fwd_idle"}, 64'(fwd), 64'd0);
        end
    endtask

    typedef struct {
        logic        v;
        logic        rdy;
        logic [31:0] alu;
        logic [3:0]  dest;
        logic        e_valid;
        logic [1:0]  e_occ;
        logic        e_ready;
        logic [31:0] e_alu;
        logic [3:0]  e_dest;
    } vec_t;

    vec_t vecs[10];

    wb_payload_t q1[$];
    wb_payload_t q0[$];

    initial begin
        wb_payload_t cur, h1, h0;
        logic mir1, mir0, of1, of0, if1, if0;

        //               v     rdy   alu         dest   valid occ    rdy   alu         dest
        vecs[0] = '{1'b1, 1'b1, 32'h10, 4'd1, 1'b1, 2'd1, 1'b1, 32'h10, 4'd1};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 4'd2, 1'b1, 2'd1, 1'b1, 32'h20, 4'd2};
        vecs[2] = '{1'b1, 1'b1, 32'h30, 4'd3, 1'b1, 2'd1, 1'b1, 32'h30, 4'd3};
        vecs[3] = '{1'b0, 1'b1, 32'h00, 4'd0, 1'b0, 2'd0, 1'b1, 32'h30, 4'd3};
        vecs[4] = '{1'b1, 1'b0, 32'hA0, 4'd3, 1'b1, 2'd1, 1'b1, 32'hA0, 4'd3};
        vecs[5] = '{1'b1, 1'b0, 32'hB0, 4'd5, 1'b1, 2'd2, 1'b0, 32'hA0, 4'd3};
        vecs[6] = '{1'b1, 1'b0, 32'hC0, 4'd7, 1'b1, 2'd2, 1'b0, 32'hA0, 4'd3};
        vecs[7] = '{1'b1, 1'b1, 32'hC0, 4'd7, 1'b1, 2'd1, 1'b1, 32'hB0, 4'd5};
        vecs[8] = '{1'b1, 1'b1, 32'hC0, 4'd7, 1'b1, 2'd1, 1'b1, 32'hC0, 4'd7};
        vecs[9] = '{1'b0, 1'b1, 32'h00, 4'd0, 1'b0, 2'd0, 1'b1, 32'hC0, 4'd7};

        // Reset held two cycles with a valid, non-zero entry offered.
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'h1234, 32'h5678, 4'd9, 32'h400, 1'b1, 1'b0);
        tick();
        tick();
        check("rst_valid", 64'(s_valid), 64'd0);
        check("rst_alu", 64'(s_alu), 64'd0);
        check("rst_dest", 64'(s_dest), 64'd0);
        check("rst_occ", 64'(s_occ), 64'd0);
        check("rst_in_ready", 64'(s_in_ready), 64'd1);
        check("rst_wb_en", 64'(s_wb_en), 64'd0);
        check("rst_z_valid", 64'(z_valid), 64'd0);
        rst = 1'b1;

        // Streaming then backpressure through the skid instance.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, 1'b1, 1'b0, vecs[i].alu, ~vecs[i].alu, vecs[i].dest,
                  vecs[i].alu + 32'h1000, vecs[i].rdy, 1'b0);
            tick();
            check($sformatf("vec%0d_valid", i), 64'(s_valid), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d_occ", i), 64'(s_occ), 64'(vecs[i].e_occ));
            check($sformatf("vec%0d_in_ready", i), 64'(s_in_ready), 64'(vecs[i].e_ready));
            check($sformatf("vec%0d_alu", i), 64'(s_alu), 64'(vecs[i].e_alu));
            check($sformatf("vec%0d_dest", i), 64'(s_dest), 64'(vecs[i].e_dest));
            check($sformatf("vec%0d_fwd", i), 64'(s_fwd), 64'(vecs[i].e_valid));
            check($sformatf("vec%0d_wbv", i), 64'(s_wbv), 64'(vecs[i].e_alu));
        end

        // Load data versus ALU result select.
        drive(1'b1, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'd9, 32'h2000, 1'b1, 1'b0);
        tick();
        check("load_wbv", 64'(s_wbv), 64'hDEADBEEF);
        check("load_mr_en", 64'(s_mr_en), 64'd1);
        drive(1'b1, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 4'd9, 32'h2004, 1'b1, 1'b0);
        tick();
        check("alu_wbv", 64'(s_wbv), 64'h100);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 32'h0, 1'b1, 1'b0);
        tick();
        check("drain_valid", 64'(s_valid), 64'd0);
        check("drain_mr_en", 64'(s_mr_en), 64'd0);

        // Flush while FULL with an entry offered; nothing flushed may emerge.
        drive(1'b1, 1'b1, 1'b0, 32'h1, 32'h0, 4'd1, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h2, 32'h0, 4'd2, 32'h0, 1'b0, 1'b0);
        tick();
        check("pre_flush_occ", 64'(s_occ), 64'd2);
        drive(1'b1, 1'b1, 1'b0, 32'h3, 32'h0, 4'd3, 32'h0, 1'b0, 1'b1);
        tick();
        check("flush_valid", 64'(s_valid), 64'd0);
        check("flush_occ", 64'(s_occ), 64'd0);
        check("flush_fwd", 64'(s_fwd), 64'd0);
        check("flush_in_ready", 64'(s_in_ready), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("post_flush%0d_valid", i), 64'(s_valid), 64'd0);
        end

        // Single-register instance: combinational in_ready and pass-through replace.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 4'd4, 32'h0, 1'b0, 1'b0);
        tick();
        check("z_hold_valid", 64'(z_valid), 64'd1);
        check("z_hold_alu", 64'(z_alu), 64'h55);
        drive(1'b1, 1'b1, 1'b0, 32'h66, 32'h0, 4'd6, 32'h0, 1'b0, 1'b0);
        #1;
        check("z_in_ready_stall", 64'(z_in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        check("z_in_ready_go", 64'(z_in_ready), 64'd1);
        tick();
        check("z_swap_occ", 64'(z_occ), 64'd1);
        check("z_swap_alu", 64'(z_alu), 64'h66);
        check("z_swap_dest", 64'(z_dest), 64'd6);

        // Random traffic against the queue model, both instances together.
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        q1.delete();
        q0.delete();
        for (int n = 0; n < 3000; n++) begin
            cur.wb_en    = 1'($urandom_range(0, 1));
            cur.mem_r_en = 1'($urandom_range(0, 1));
            cur.alu_res  = $urandom;
            cur.mem_data = $urandom;
            cur.dest     = 4'($urandom_range(0, 15));
            cur.pc       = $urandom;
            drive($urandom_range(0, 3) != 0, cur.wb_en, cur.mem_r_en, cur.alu_res,
                  cur.mem_data, cur.dest, cur.pc, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 150) != 0);
            #1;
            mir1 = (q1.size() < 2);
            mir0 = out_ready || (q0.size() == 0);
            check("rnd_s_in_ready", 64'(s_in_ready), 64'(mir1));
            check("rnd_z_in_ready", 64'(z_in_ready), 64'(mir0));
            of1 = (q1.size() > 0) && out_ready;
            of0 = (q0.size() > 0) && out_ready;
            if1 = in_valid && mir1;
            if0 = in_valid && mir0;
            tick();
            if (!rst || flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (of1) void'(q1.pop_front());
                if (if1) q1.push_back(cur);
                if (of0) void'(q0.pop_front());
                if (if0) q0.push_back(cur);
            end
            h1 = (q1.size() > 0) ? q1[0] : '0;
            h0 = (q0.size() > 0) ? q0[0] : '0;
            check_dut("rnd_s", q1.size(), h1, s_valid, s_wb_en, s_mr_en, s_alu, s_mdata,
                      s_dest, s_pc, s_wbv, s_fwd, s_occ);
            check_dut("rnd_z", q0.size(), h0, z_valid, z_wb_en, z_mr_en, z_alu, z_mdata,
                      z_dest, z_pc, z_wbv, z_fwd, z_occ);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
